// File: rtl/mul32_seq_ctrl.sv
// 32x32 unsigned multiply sequenced over four passes through one shared 16x16
// multiplier, with the 64-bit result returned on a valid/ready handshake.
module mul32_seq_ctrl #(
  parameter bit PP_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  step_q, step_d;
  logic [63:0] acc_q, acc_d, out_p_q, out_p_d;
  logic [31:0] pp_q, pp_d;
  logic [1:0]  pp_tag_q, pp_tag_d;
  logic        pp_vld_q, pp_vld_d;
  logic [63:0] add_term, acc_sum;
  logic        accept;

  // Step k selects the operand halves; k=1 and k=2 both land at bit 16.
  function automatic logic [63:0] align_pp(input logic [31:0] p, input logic [1:0] k);
    logic [63:0] r;
    case (k)
      2'd0:    r = {32'd0, p};
      2'd3:    r = {p, 32'd0};
      default: r = {16'd0, p, 16'd0};
    endcase
    return r;
  endfunction

  assign in_ready  = !rst_n || (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = rst_n && in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_p     = out_p_q;
  assign busy      = (state_q != IDLE);
  assign acc_sum   = acc_q + add_term;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    step_d   = step_q;
    acc_d    = acc_sum;
    out_p_d  = out_p_q;
    pp_d     = pp_q;
    pp_tag_d = pp_tag_q;
    pp_vld_d = 1'b0;
    mul_a    = 16'd0;
    mul_b    = 16'd0;
    add_term = 64'd0;

    if (state_q == CALC) begin
      mul_a = step_q[1] ? a_q[31:16] : a_q[15:0];
      mul_b = step_q[0] ? b_q[31:16] : b_q[15:0];
    end

    if (PP_REG) begin
      if (pp_vld_q) add_term = align_pp(pp_q, pp_tag_q);
      if (state_q == CALC) begin
        pp_d     = mul_p;
        pp_tag_d = step_q;
        pp_vld_d = 1'b1;
      end
    end else if (state_q == CALC) begin
      add_term = align_pp(mul_p, step_q);
    end

    case (state_q)
      CALC: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          if (PP_REG) begin
            state_d = FLUSH;
          end else begin
            state_d = DONE;
            out_p_d = acc_sum;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
        out_p_d = acc_sum;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // A consumed result and a new accept may share the same edge.
    if (accept) begin
      state_d = CALC;
      a_d     = in_a;
      b_d     = in_b;
      step_d  = 2'd0;
      acc_d   = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      step_q   <= 2'd0;
      acc_q    <= 64'd0;
      out_p_q  <= 64'd0;
      pp_q     <= 32'd0;
      pp_tag_q <= 2'd0;
      pp_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      out_p_q  <= out_p_d;
      pp_q     <= pp_d;
      pp_tag_q <= pp_tag_d;
      pp_vld_q <= pp_vld_d;
    end
  end

endmodule

// File: doc/mul32_seq_ctrl.md
Name: mul32_seq_ctrl

Overview:
Sequencing controller that computes a 32x32 unsigned product by time-multiplexing one shared 16x16 combinational multiplier over four partial-product steps. It accumulates the partial products into a 64-bit register and returns the result over a valid/ready handshake. It sits between an operand producer and the existing 16x16 multiplier instance, so one multiplier array serves 32-bit requests in place of four parallel arrays.

Parameters:
PP_REG, 0, 1 = register the multiplier product before accumulation; adds one cycle of latency. 0 = accumulate the combinational product directly.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept an operand pair
in_a  input  32  multiplicand
in_b  input  32  multiplier
mul_a  output  16  operand A to shared 16x16 multiplier
mul_b  output  16  operand B to shared 16x16 multiplier
mul_p  input  32  product returned by shared multiplier, same cycle (combinational)
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_p  output  64  product in_a*in_b
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low at a clk edge), regardless of state:
  - state=IDLE, step counter=0, accumulator=0, out_p=0.
  - out_valid=0, busy=0, in_ready=1 (in_ready is high while rst_n is low).
  - Any in-flight operation is discarded, with no output.
- States: IDLE, CALC, (PP_REG=1 only) FLUSH, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept: in_valid & in_ready at an edge.
  - Operands are latched into internal registers a_q and b_q.
  - step=0, accumulator cleared, state goes to CALC.
  - Inputs are ignored at every other time.
- CALC, step k=0..3, mul_a/mul_b drive:
  - k=0: a_q[15:0], b_q[15:0], shift 0
  - k=1: a_q[15:0], b_q[31:16], shift 16
  - k=2: a_q[31:16], b_q[15:0], shift 16
  - k=3: a_q[31:16], b_q[31:16], shift 32
- PP_REG=0:
  - Each CALC edge does acc += zero-extended mul_p << shift(k), with 64-bit modulo arithmetic. Overflow cannot occur for unsigned operands.
  - After k=3, state goes to DONE.
- PP_REG=1:
  - mul_p is registered with its shift tag. Accumulation lags the issue by one cycle.
  - After issuing k=3, state goes to FLUSH, where the final partial product is added. FLUSH then goes to DONE.
- Outside CALC: mul_a=0, mul_b=0, so the shared multiplier sees a quiescent input.
- DONE:
  - out_valid=1, out_p=acc. out_p is held stable while out_valid & !out_ready.
  - On out_valid & out_ready, the result is consumed.
  - If in_valid is also high in that cycle, the new pair is accepted and the state goes straight to CALC (back-to-back). Otherwise the state goes to IDLE.
  - out_valid deasserts in the cycle after consumption unless a new result is already due.
- out_p holds its last value after consumption until the next DONE; the consumer qualifies it with out_valid.
- Latency, counted from the accept edge to the first cycle with out_valid=1: 4 cycles (PP_REG=0) or 5 cycles (PP_REG=1).
- Throughput with out_ready tied high: one result per 5 cycles (PP_REG=0) or 6 cycles (PP_REG=1).
- busy=1 in CALC, FLUSH and DONE.
- in_valid is ignored while busy, except in the DONE & out_ready cycle.
- Operand changes on in_a/in_b after acceptance have no effect.

Test Plan:
- 0x0000FFFF*0x0000FFFF, out_ready=1, PP_REG=0 -> out_valid high exactly 4 cycles after the accept edge, out_p=0x00000000FFFE0001, one-cycle pulse.
- 0xFFFFFFFF*0xFFFFFFFF -> out_p=0xFFFFFFFE00000001. Repeat with PP_REG=1 -> same value, latency 5.
- 0x00010000*0x00010000 then 0x80000000*0x00000002 -> 0x0000000100000000, then 0x0000000100000000. Check that mul_a/mul_b follow the k=0..3 order each cycle.
- Backpressure: hold out_ready=0 for 10 cycles after DONE with in_valid=1 and in_a/in_b toggling -> out_valid, out_p stable, in_ready=0, no new accept. Release out_ready -> the pending pair is accepted in the same cycle and its result arrives 4 cycles later.
- Back-to-back: in_valid and out_ready tied high, 8 random operand pairs -> 8 correct products, exactly 5 cycles apart (PP_REG=0), no drops or duplicates.
- Reset mid-operation: drop rst_n for 1 cycle during CALC step 2 -> next edge gives IDLE, out_valid=0, busy=0, in_ready=1, out_p=0. A fresh 3*5 then yields out_p=15 with no stale partial products.
